// File: rtl/vanilla_decode_queue.sv
// Fetch-to-issue decoupling queue for the vanilla core: decodes on enqueue,
// stores instruction/PC/decode bundles in a circular buffer, keeps issue stats.
package vanilla_decode_queue_pkg;
  typedef enum logic [2:0] {eFADD, eFSUB, eFMUL, eFMIN, eFMAX} fpu_float_op_e;

  typedef struct packed {
    logic write_rd;
    logic read_rs1;
    logic read_rs2;
    logic is_load_op;
    logic is_store_op;
    logic is_branch_op;
    logic is_jal_op;
    logic is_jalr_op;
    logic is_imul_op;
    logic is_idiv_op;
    logic is_fp_op;
    logic write_frd;
    logic read_frs1;
    logic read_frs2;
    logic unsupported;
  } decode_s;

  typedef struct packed {
    logic          is_fpu_float_op;
    fpu_float_op_e fpu_float_op;
  } fp_decode_s;
endpackage

module vanilla_decode_queue
  import vanilla_decode_queue_pkg::*;
#(
  parameter int unsigned els_p        = 4,
  parameter int unsigned pc_width_p   = 22,
  parameter int unsigned stat_width_p = 16
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           v_i,
  input  logic [31:0]                    instr_i,
  input  logic [pc_width_p-1:0]          pc_i,
  output logic                           ready_o,
  input  logic                           flush_i,
  output logic                           v_o,
  output logic [31:0]                    instr_o,
  output logic [pc_width_p-1:0]          pc_o,
  output logic [$bits(decode_s)-1:0]     decode_o,
  output logic [$bits(fp_decode_s)-1:0]  fp_decode_o,
  output logic                           illegal_o,
  input  logic                           yumi_i,
  output logic [$clog2(els_p+1)-1:0]     count_o,
  output logic [stat_width_p-1:0]        issued_count_o,
  output logic                           illegal_seen_o
);

  localparam int unsigned ptr_w_lp = $clog2(els_p);
  localparam int unsigned cnt_w_lp = $clog2(els_p+1);

  logic [31:0]            r_instr [els_p];
  logic [pc_width_p-1:0]  r_pc    [els_p];
  decode_s                r_dec   [els_p];
  fp_decode_s             r_fp    [els_p];
  logic                   r_ill   [els_p];
  logic [ptr_w_lp-1:0]    r_head, r_tail;
  logic [cnt_w_lp-1:0]    r_count;
  logic [stat_width_p-1:0] r_issued;
  logic                   r_ill_seen;

  decode_s    w_dec;
  fp_decode_s w_fp;
  logic       w_illegal, w_enq, w_deq;
  logic [6:0] w_opcode, w_funct7;
  logic [2:0] w_funct3;

  assign w_opcode = instr_i[6:0];
  assign w_funct3 = instr_i[14:12];
  assign w_funct7 = instr_i[31:25];

  // RV32IM + single-precision FP subset decoder; anything else is unsupported
  always_comb begin
    w_dec = '0;
    w_fp  = '0;
    unique case (w_opcode)
      7'b0110111, 7'b0010111: w_dec.write_rd = 1'b1;
      7'b1101111: begin w_dec.write_rd = 1'b1; w_dec.is_jal_op = 1'b1; end
      7'b1100111: begin
        w_dec.write_rd = 1'b1; w_dec.read_rs1 = 1'b1; w_dec.is_jalr_op = 1'b1;
      end
      7'b1100011: begin
        w_dec.read_rs1 = 1'b1; w_dec.read_rs2 = 1'b1; w_dec.is_branch_op = 1'b1;
      end
      7'b0000011: begin
        w_dec.write_rd = 1'b1; w_dec.read_rs1 = 1'b1; w_dec.is_load_op = 1'b1;
      end
      7'b0100011: begin
        w_dec.read_rs1 = 1'b1; w_dec.read_rs2 = 1'b1; w_dec.is_store_op = 1'b1;
      end
      7'b0010011: begin w_dec.write_rd = 1'b1; w_dec.read_rs1 = 1'b1; end
      7'b0110011: begin
        w_dec.write_rd = 1'b1; w_dec.read_rs1 = 1'b1; w_dec.read_rs2 = 1'b1;
        if (w_funct7 == 7'b0000001) begin
          if (w_funct3 == 3'b000)     w_dec.is_imul_op  = 1'b1;
          else if (w_funct3[2])       w_dec.is_idiv_op  = 1'b1;
          else                        w_dec.unsupported = 1'b1;
        end else if (w_funct7 == 7'b0100000) begin
          w_dec.unsupported = !(w_funct3 == 3'b000 || w_funct3 == 3'b101);
        end else if (w_funct7 != 7'b0000000) begin
          w_dec.unsupported = 1'b1;
        end
      end
      7'b1010011: begin
        w_dec.is_fp_op  = 1'b1; w_dec.write_frd = 1'b1;
        w_dec.read_frs1 = 1'b1; w_dec.read_frs2 = 1'b1;
        w_fp.is_fpu_float_op = 1'b1;
        unique case (w_funct7)
          7'b0000000: w_fp.fpu_float_op = eFADD;
          7'b0000100: w_fp.fpu_float_op = eFSUB;
          7'b0001000: w_fp.fpu_float_op = eFMUL;
          7'b0010100: begin
            if (w_funct3 == 3'b000)      w_fp.fpu_float_op = eFMIN;
            else if (w_funct3 == 3'b001) w_fp.fpu_float_op = eFMAX;
            else                         w_dec.unsupported = 1'b1;
          end
          default: w_dec.unsupported = 1'b1;
        endcase
      end
      default: w_dec.unsupported = 1'b1;
    endcase
  end

  assign w_illegal = w_dec.unsupported | (instr_i == 32'h0000_0000) | (instr_i == 32'hFFFF_FFFF);

  assign ready_o = ~reset_i & (r_count < cnt_w_lp'(els_p));
  assign v_o     = (r_count != '0);
  assign w_enq   = v_i & ready_o & ~flush_i;
  assign w_deq   = yumi_i & v_o;

  // Queue storage, pointers and statistics
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_issued   <= '0;
      r_ill_seen <= 1'b0;
      for (int i = 0; i < int'(els_p); i++) begin
        r_instr[i] <= '0;
        r_pc[i]    <= '0;
        r_dec[i]   <= '0;
        r_fp[i]    <= '0;
        r_ill[i]   <= 1'b0;
      end
    end else begin
      if (w_enq) begin
        r_instr[r_tail] <= instr_i;
        r_pc[r_tail]    <= pc_i;
        r_dec[r_tail]   <= w_dec;
        r_fp[r_tail]    <= w_fp;
        r_ill[r_tail]   <= w_illegal;
        r_tail          <= r_tail + ptr_w_lp'(1);
        if (w_illegal) r_ill_seen <= 1'b1;
      end
      if (flush_i) begin
        r_head  <= r_tail;
        r_count <= '0;
      end else begin
        if (w_deq) r_head <= r_head + ptr_w_lp'(1);
        if (w_enq && !w_deq)      r_count <= r_count + cnt_w_lp'(1);
        else if (!w_enq && w_deq) r_count <= r_count - cnt_w_lp'(1);
      end
      if (w_deq && (r_issued != '1)) r_issued <= r_issued + stat_width_p'(1);
    end
  end

  assign instr_o        = r_instr[r_head];
  assign pc_o           = r_pc[r_head];
  assign decode_o       = r_dec[r_head];
  assign fp_decode_o    = r_fp[r_head];
  assign illegal_o      = r_ill[r_head];
  assign count_o        = r_count;
  assign issued_count_o = r_issued;
  assign illegal_seen_o = r_ill_seen;

  a_no_yumi_when_empty: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o);

endmodule

// File: tb/tb_vanilla_decode_queue.sv
// Directed self-checking bench for vanilla_decode_queue (default and 4-bit stat instances).
module tb_vanilla_decode_queue;
  import vanilla_decode_queue_pkg::*;

  localparam int unsigned PW = 22;

  logic clk, reset, v_in, flush, yumi;
  logic [31:0] instr_in;
  logic [PW-1:0] pc_in;

  logic ready, v_out, ill, seen;
  logic [31:0] instr_out;
  logic [PW-1:0] pc_out;
  decode_s dec;
  fp_decode_s fp;
  logic [2:0] count;
  logic [15:0] issued;

  logic s_ready, s_v, s_ill, s_seen;
  logic [31:0] s_instr;
  logic [PW-1:0] s_pc;
  decode_s s_dec;
  fp_decode_s s_fp;
  logic [2:0] s_count;
  logic [3:0] s_issued;

  int n_checks = 0;
  int n_fail = 0;
  int exp_issued = 0;

  vanilla_decode_queue dut (
    .clk_i(clk), .reset_i(reset), .v_i(v_in), .instr_i(instr_in), .pc_i(pc_in),
    .ready_o(ready), .flush_i(flush), .v_o(v_out), .instr_o(instr_out), .pc_o(pc_out),
    .decode_o(dec), .fp_decode_o(fp), .illegal_o(ill), .yumi_i(yumi),
    .count_o(count), .issued_count_o(issued), .illegal_seen_o(seen)
  );

  vanilla_decode_queue #(.stat_width_p(4)) dut_sat (
    .clk_i(clk), .reset_i(reset), .v_i(v_in), .instr_i(instr_in), .pc_i(pc_in),
    .ready_o(s_ready), .flush_i(flush), .v_o(s_v), .instr_o(s_instr), .pc_o(s_pc),
    .decode_o(s_dec), .fp_decode_o(s_fp), .illegal_o(s_ill), .yumi_i(yumi),
    .count_o(s_count), .issued_count_o(s_issued), .illegal_seen_o(s_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // addi x1, x0, n
  function automatic logic [31:0] mk(input int n);
    mk = {12'(n), 5'd0, 3'b000, 5'd1, 7'b0010011};
  endfunction

  initial begin
    reset = 1'b1; v_in = 1'b0; flush = 1'b0; yumi = 1'b0;
    instr_in = '0; pc_in = '0;
    step(); step();
    chk("rst_ready", ready, 0);
    chk("rst_count", count, 0);
    chk("rst_v", v_out, 0);
    chk("rst_issued", issued, 0);
    chk("rst_seen", seen, 0);
    chk("rst_s_ready", s_ready, 0);
    reset = 1'b0;
    #1;
    chk("ready_after_rst", ready, 1);

    // fill
    v_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      instr_in = mk(i + 1); pc_in = PW'(16 + i);
      step();
    end
    v_in = 1'b0; yumi = 1'b1;
    #1;
    chk("full_ready", ready, 0);
    chk("full_count", count, 4);
    chk("full_v", v_out, 1);
    // drain in FIFO order
    for (int i = 0; i < 4; i++) begin
      chk("drain_instr", instr_out, mk(i + 1));
      chk("drain_pc", pc_out, 64'(16 + i));
      chk("drain_ill", ill, 0);
      chk("drain_s_pc", s_pc, 64'(16 + i));
      step();
    end
    yumi = 1'b0;
    chk("drained_v", v_out, 0);
    chk("drained_count", count, 0);
    chk("drained_issued", issued, 4);
    chk("drained_s_issued", s_issued, 4);

    reset = 1'b1; step(); reset = 1'b0;
    chk("rst2_issued", issued, 0);

    // streaming with one resident entry
    v_in = 1'b1; instr_in = mk(100); pc_in = PW'(100);
    step();
    chk("stream_pre_count", count, 1);
    yumi = 1'b1;
    for (int k = 0; k < 20; k++) begin
      instr_in = mk(101 + k); pc_in = PW'(101 + k);
      chk("stream_instr", instr_out, mk(100 + k));
      chk("stream_pc", pc_out, 64'(100 + k));
      chk("stream_count", count, 1);
      step();
    end
    v_in = 1'b0; yumi = 1'b0;
    exp_issued = 20;
    chk("stream_count_end", count, 1);
    chk("stream_issued", issued, 64'(exp_issued));
    chk("sat_issued", s_issued, 15);
    chk("sat_count", s_count, 1);
    chk("stream_last", instr_out, mk(120));
    yumi = 1'b1; step(); yumi = 1'b0; exp_issued++;

    // decode content
    v_in = 1'b1; instr_in = 32'h02B50533; pc_in = PW'(200);
    step();
    instr_in = 32'h00B57553; pc_in = PW'(201);
    step();
    v_in = 1'b0;
    chk("mul_imul", dec.is_imul_op, 1);
    chk("mul_wrd", dec.write_rd, 1);
    chk("mul_ill", ill, 0);
    chk("mul_s_imul", s_dec.is_imul_op, 1);
    yumi = 1'b1; step(); yumi = 1'b0; exp_issued++;
    chk("fadd_float", fp.is_fpu_float_op, 1);
    chk("fadd_op", 64'(fp.fpu_float_op), 64'(eFADD));
    chk("fadd_frd", dec.write_frd, 1);
    chk("fadd_ill", ill, 0);
    chk("fadd_s_float", s_fp.is_fpu_float_op, 1);
    chk("seen_before_ill", seen, 0);
    yumi = 1'b1; step(); yumi = 1'b0; exp_issued++;

    // illegal instructions
    v_in = 1'b1; instr_in = 32'h0000_0000; pc_in = PW'(300);
    step();
    instr_in = 32'h02B51533; pc_in = PW'(301);
    step();
    v_in = 1'b0;
    chk("ill_zero", ill, 1);
    chk("ill_seen", seen, 1);
    chk("ill_s_zero", s_ill, 1);
    yumi = 1'b1; step(); yumi = 1'b0; exp_issued++;
    chk("ill_mulh", ill, 1);
    chk("ill_mulh_count", count, 1);
    flush = 1'b1; step(); flush = 1'b0;
    chk("ill_flush_count", count, 0);
    chk("ill_flush_v", v_out, 0);
    chk("ill_seen_flush", seen, 1);
    chk("ill_s_seen", s_seen, 1);

    // flush with simultaneous enqueue and dequeue
    v_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      instr_in = mk(50 + i); pc_in = PW'(50 + i);
      step();
    end
    chk("fl_pre_count", count, 3);
    flush = 1'b1; instr_in = mk(99); pc_in = PW'(99); yumi = 1'b1;
    step();
    flush = 1'b0; v_in = 1'b0; yumi = 1'b0; exp_issued++;
    chk("fl_count", count, 0);
    chk("fl_v", v_out, 0);
    chk("fl_issued", issued, 64'(exp_issued));
    chk("fl_s_v", s_v, 0);
    v_in = 1'b1; instr_in = mk(60); pc_in = PW'(60);
    step();
    v_in = 1'b0;
    chk("fl_after_count", count, 1);
    chk("fl_after_instr", instr_out, mk(60));
    chk("fl_after_s_instr", s_instr, mk(60));

    // reset mid-stream, handshakes still active
    v_in = 1'b1; yumi = 1'b1;
    for (int i = 0; i < 3; i++) begin
      instr_in = mk(70 + i); pc_in = PW'(70 + i);
      step();
    end
    chk("mid_count", count, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_ready", ready, 0);
    step();
    chk("mid_rst_count", count, 0);
    chk("mid_rst_v", v_out, 0);
    chk("mid_rst_issued", issued, 0);
    chk("mid_rst_seen", seen, 0);
    chk("mid_rst_s_issued", s_issued, 0);
    step();
    chk("mid_rst_count2", count, 0);
    reset = 1'b0; v_in = 1'b0; yumi = 1'b0;
    #1;
    chk("mid_ready_after", ready, 1);
    step();
    chk("mid_end_count", count, 0);
    chk("mid_end_ready", ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
